// File: rtl/hdc_fusion_scheduler.sv
// hdc_fusion_scheduler: collects an in-order feature frame from a serial
// sensor stream, issues it to one hdc_sensor_fusion engine on a period slot
// (or as soon as it is complete), drains the valence/arousal result and
// returns it tagged with the frame number and the measured engine latency.
// Only one frame is ever outstanding; missed period slots are counted.
module hdc_fusion_scheduler #(
  parameter  int NUM_CHANNEL   = 214,
  parameter  int CHANNEL_WIDTH = 4,
  parameter  int PERIOD_CYCLES = 100000,
  parameter  int TAG_WIDTH     = 8,
  parameter  int LAT_WIDTH     = 20,
  localparam int IDX_WIDTH     = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1,
  localparam int TIMER_WIDTH   = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic                                 period_en,
  input  logic                                 ch_valid,
  output logic                                 ch_ready,
  input  logic [IDX_WIDTH-1:0]                 ch_idx,
  input  logic [CHANNEL_WIDTH-1:0]             ch_data,
  output logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top,
  output logic                                 fin_valid,
  input  logic                                 fin_ready,
  input  logic                                 valence,
  input  logic                                 arousal,
  input  logic                                 dout_valid,
  output logic                                 dout_ready,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic                                 res_valence,
  output logic                                 res_arousal,
  output logic [TAG_WIDTH-1:0]                 res_tag,
  output logic [LAT_WIDTH-1:0]                 res_latency,
  output logic                                 err_seq,
  output logic [7:0]                           overrun_cnt
);

  typedef enum logic [2:0] {
    COLLECT   = 3'd0,
    WAIT_SLOT = 3'd1,
    ISSUE     = 3'd2,
    WAIT_RES  = 3'd3,
    DELIVER   = 3'd4
  } state_t;

  localparam logic [IDX_WIDTH-1:0]   LAST_IDX   = IDX_WIDTH'(NUM_CHANNEL - 1);
  localparam logic [TIMER_WIDTH-1:0] LAST_TICK  = TIMER_WIDTH'(PERIOD_CYCLES - 1);

  // Saturating increment for the latency counter.
  function automatic logic [LAT_WIDTH-1:0] lat_sat_inc(input logic [LAT_WIDTH-1:0] v);
    return (&v) ? v : v + LAT_WIDTH'(1);
  endfunction

  // Saturating increment for the overrun counter.
  function automatic logic [7:0] ovr_sat_inc(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  state_t                               state_r, state_nx_s;
  logic [IDX_WIDTH-1:0]                 cnt_r;
  logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] frame_r;
  logic [TIMER_WIDTH-1:0]               timer_r;
  logic                                 token_r;
  logic [7:0]                           overrun_r;
  logic                                 err_seq_r;
  logic [TAG_WIDTH-1:0]                 tag_r;
  logic [LAT_WIDTH-1:0]                 lat_r;
  logic                                 ch_ready_r, fin_valid_r, dout_ready_r, res_valid_r;
  logic                                 res_valence_r, res_arousal_r;
  logic [TAG_WIDTH-1:0]                 res_tag_r;
  logic [LAT_WIDTH-1:0]                 res_latency_r;

  logic accept_s, drop_s, consume_s, fin_hs_s, dout_hs_s, res_hs_s, wrap_s;

  assign wrap_s = period_en && (timer_r == LAST_TICK);

  // Next-state decode and per-state handshake strobes.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    drop_s     = 1'b0;
    consume_s  = 1'b0;
    fin_hs_s   = 1'b0;
    dout_hs_s  = 1'b0;
    res_hs_s   = 1'b0;
    case (state_r)
      COLLECT: begin
        if (ch_valid) begin
          if (ch_idx == cnt_r) begin
            accept_s = 1'b1;
            if (ch_idx == LAST_IDX) begin
              state_nx_s = WAIT_SLOT;
            end else begin
              state_nx_s = COLLECT;
            end
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          state_nx_s = COLLECT;
        end
      end
      WAIT_SLOT: begin
        if (enable && (!period_en || token_r)) begin
          consume_s  = 1'b1;
          state_nx_s = ISSUE;
        end else begin
          state_nx_s = WAIT_SLOT;
        end
      end
      ISSUE: begin
        if (fin_ready) begin
          fin_hs_s   = 1'b1;
          state_nx_s = WAIT_RES;
        end else begin
          state_nx_s = ISSUE;
        end
      end
      WAIT_RES: begin
        if (dout_valid) begin
          dout_hs_s  = 1'b1;
          state_nx_s = DELIVER;
        end else begin
          state_nx_s = WAIT_RES;
        end
      end
      DELIVER: begin
        if (res_ready) begin
          res_hs_s   = 1'b1;
          state_nx_s = COLLECT;
        end else begin
          state_nx_s = DELIVER;
        end
      end
      default: begin
        state_nx_s = COLLECT;
      end
    endcase
  end

  // State register with handshake outputs registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= COLLECT;
      ch_ready_r   <= 1'b1;
      fin_valid_r  <= 1'b0;
      dout_ready_r <= 1'b0;
      res_valid_r  <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      ch_ready_r   <= (state_nx_s == COLLECT);
      fin_valid_r  <= (state_nx_s == ISSUE);
      dout_ready_r <= (state_nx_s == WAIT_RES);
      res_valid_r  <= (state_nx_s == DELIVER);
    end
  end

  // Frame assembly: in-order samples land in the frame, others raise err_seq.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= '0;
      frame_r   <= '0;
      err_seq_r <= 1'b0;
    end else begin
      if (accept_s) begin
        frame_r[int'(cnt_r)*CHANNEL_WIDTH +: CHANNEL_WIDTH] <= ch_data;
        cnt_r <= (cnt_r == LAST_IDX) ? '0 : cnt_r + IDX_WIDTH'(1);
      end
      if (drop_s) begin
        err_seq_r <= 1'b1;
      end
    end
  end

  // Period timer, slot token and missed-slot counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_r   <= '0;
      token_r   <= 1'b0;
      overrun_r <= 8'd0;
    end else begin
      if (!period_en || wrap_s) begin
        timer_r <= '0;
      end else begin
        timer_r <= timer_r + TIMER_WIDTH'(1);
      end
      // A slot consumed on the wrap edge frees the token for the new slot.
      if (consume_s) begin
        token_r <= wrap_s;
      end else if (wrap_s) begin
        token_r <= 1'b1;
      end
      if (wrap_s && token_r && !consume_s) begin
        overrun_r <= ovr_sat_inc(overrun_r);
      end
    end
  end

  // Engine latency measurement, result capture and frame tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_r         <= '0;
      tag_r         <= '0;
      res_valence_r <= 1'b0;
      res_arousal_r <= 1'b0;
      res_tag_r     <= '0;
      res_latency_r <= '0;
    end else begin
      if (fin_hs_s) begin
        lat_r <= '0;
      end else if (state_r == WAIT_RES) begin
        lat_r <= lat_sat_inc(lat_r);
      end
      // The capture edge itself is one more clock of latency.
      if (dout_hs_s) begin
        res_valence_r <= valence;
        res_arousal_r <= arousal;
        res_tag_r     <= tag_r;
        res_latency_r <= lat_sat_inc(lat_r);
      end
      if (res_hs_s) begin
        tag_r <= tag_r + TAG_WIDTH'(1);
      end
    end
  end

  assign ch_ready     = ch_ready_r;
  assign fin_valid    = fin_valid_r;
  assign dout_ready   = dout_ready_r;
  assign res_valid    = res_valid_r;
  assign features_top = frame_r;
  assign res_valence  = res_valence_r;
  assign res_arousal  = res_arousal_r;
  assign res_tag      = res_tag_r;
  assign res_latency  = res_latency_r;
  assign err_seq      = err_seq_r;
  assign overrun_cnt  = overrun_r;

endmodule

// File: doc/hdc_fusion_scheduler.md
Name: hdc_fusion_scheduler

Overview:
- Front-end controller that sequences one hdc_sensor_fusion engine.
- Collects per-channel feature samples in order from a serial sensor stream into a full feature frame.
- Issues the frame to the engine on a programmable period slot (default 1 ms), drains the valence/arousal result, and returns it with a frame tag and the measured engine latency.
- Enforces a single outstanding frame and counts missed period slots.

Parameters:
- NUM_CHANNEL, 214, channels per frame (SEFUAM total).
- CHANNEL_WIDTH, 4, bits per channel feature.
- PERIOD_CYCLES, 100000, issue-slot period in clocks (1 ms at 10 ns); minimum 2.
- TAG_WIDTH, 8, frame tag width.
- LAT_WIDTH, 20, latency counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- enable  in  1  allows new frames to be issued.
- period_en  in  1  1 = issue only on period slots; 0 = issue as soon as the frame is complete.
- ch_valid  in  1  sample valid.
- ch_ready  out  1  sample accepted.
- ch_idx  in  ceilLog2(NUM_CHANNEL)  channel index of the sample.
- ch_data  in  CHANNEL_WIDTH  feature value.
- features_top  out  NUM_CHANNEL*CHANNEL_WIDTH  frame to engine; channel k occupies bits [k*CW +: CW].
- fin_valid  out  1  frame valid to engine.
- fin_ready  in  1  engine accepts frame.
- valence, arousal  in  1 each  engine labels.
- dout_valid  in  1  engine result valid.
- dout_ready  out  1  scheduler accepts result.
- res_valid  out  1  result valid to consumer.
- res_ready  in  1  consumer accepts result.
- res_valence, res_arousal  out  1 each  registered labels.
- res_tag  out  TAG_WIDTH  tag of the frame that produced this result.
- res_latency  out  LAT_WIDTH  clocks from fin handshake to dout handshake; saturating.
- err_seq  out  1  sticky: an out-of-order ch_idx was seen.
- overrun_cnt  out  8  saturating count of missed period slots.

Behaviour:
- Reset (rst=0, async): state=COLLECT, channel counter=0, tag=0, timer=0, slot token=0.
  - All outputs 0, except ch_ready=1 once rst is released.
  - features_top=0.
- Period timer:
  - Counts 0..PERIOD_CYCLES-1 while period_en=1; held at 0 while period_en=0.
  - Wrap sets the slot token.
  - If a wrap occurs while the token is already set, overrun_cnt increments (saturates at 255).
- COLLECT: ch_ready=1.
  - On ch_valid & ch_idx==counter: write ch_data into the frame register at that channel and increment the counter.
  - On ch_valid & ch_idx!=counter: sample is consumed and dropped, err_seq set, counter unchanged.
  - When the accepted index is NUM_CHANNEL-1: counter->0, next state WAIT_SLOT.
- WAIT_SLOT: ch_ready=0.
  - Go to ISSUE when enable=1 and (period_en=0 or token=1).
  - Token clears on the same edge as the transition.
  - A token set and consumed in the same cycle counts as consumed (no overrun).
- ISSUE: fin_valid=1, features_top stable.
  - On fin_valid & fin_ready: latency counter cleared, state WAIT_RES.
  - fin_valid is never dropped before the handshake.
- WAIT_RES: dout_ready=1, latency counter +1 per clock (saturating at all-ones).
  - On dout_valid: capture valence, arousal, latency and the current tag; state DELIVER.
- DELIVER: res_valid=1 with captured values stable until res_ready.
  - On handshake: tag +1 (wraps modulo 2^TAG_WIDTH), res_valid=0, state COLLECT.
- No new frame collection until DELIVER completes; ch_ready=0 in all states except COLLECT.
- Issue-to-handshake latency: fin_valid rises the cycle after the WAIT_SLOT condition is met.
- enable=0 only blocks WAIT_SLOT->ISSUE; an in-flight frame completes normally.
- Reset mid-operation: everything cleared immediately; fin_valid, dout_ready and res_valid fall asynchronously; a partial frame is discarded.
- err_seq is cleared only by reset.

Test Plan:
- NUM_CHANNEL=4, period_en=0, samples idx 0..3 data 1,2,3,4; engine fin_ready=1, dout_valid 5 cycles later with v=1, a=0 -> features_top=0x4321, res_valid with v=1, a=0, tag=0, latency=5; second frame gives tag=1.
- PERIOD_CYCLES=10, period_en=1, frame complete at cycle 3 -> fin_valid not before the first timer wrap (cycle 10); fin_valid held 3 cycles while fin_ready=0, single handshake.
- Sample sequence idx 0,2,1,2,3 -> err_seq=1; idx 2 dropped once; frame completes with the correct data for 0..3.
- PERIOD_CYCLES=10, consumer holds res_ready=0 for 25 cycles -> overrun_cnt=1 or 2 per elapsed wraps; ch_ready=0 throughout; result fields stable.
- enable=0 with frame complete and token set -> no fin_valid; enable=1 -> issue next cycle.
- Assert rst=0 in WAIT_RES -> fin_valid, dout_ready and res_valid go 0 immediately; after release a fresh frame issues with tag=0.
